serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial N-bit adder: adds a + b + cin one bit per clock, LSB first, using a single full-adder slice and a carry flip-flop.
- Complements the two-bit ripple subtractor in the arithmetic lab set. It trades area for latency and is driven by a start/done handshake from a controlling FSM or testbench.
- Produces sum, carry-out and signed overflow, held stable until the next operation completes.

Parameters:
- WIDTH, 4, operand and sum width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to begin an addition; sampled only in IDLE or DONE
- a  input  WIDTH  augend, captured on accepted start
- b  input  WIDTH  addend, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: result registers just updated
- sum  output  WIDTH  registered result a+b+cin (mod 2^WIDTH)
- cout  output  1  registered carry out of MSB
- overflow  output  1  registered signed (two's-complement) overflow

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; internal shift regs, carry and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge -> capture a, b into shift regs, carry<=cin, count<=0, state<=RUN.
  - start=0 -> stay in IDLE.
- RUN, each edge:
  - bit = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry).
  - Shift A and B right; shift bit into the MSB of the partial-sum register.
  - count++.
- RUN, on the edge processing bit WIDTH-1:
  - sum <= completed partial sum; cout <= final carry.
  - overflow <= carry into MSB XOR carry out of MSB.
  - state <= DONE.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 -> accepted as in IDLE (back-to-back, state<=RUN); otherwise state<=IDLE.
- busy=1 exactly while state=RUN; done and busy are never high together.
- Latency: start sampled at edge 0 -> busy high from edge 0 to edge WIDTH -> done high in the cycle after edge WIDTH. That is WIDTH+1 clocks from start to done.
- start while RUN: ignored. Operand inputs may change freely after capture without affecting the result.
- sum/cout/overflow change only on the final RUN edge. They hold their previous values throughout RUN and IDLE.
- Reset mid-RUN: operation abandoned, all outputs cleared, no done pulse.
- Arithmetic is unsigned mod 2^WIDTH plus cout. overflow follows signed interpretation. cin=1 with b=~x yields a-x, matching the subtractor convention.

Test Plan (WIDTH=4):
- Reset released, start=1, a=5, b=3, cin=0 -> busy high 4 cycles, done pulse on the 5th cycle; sum=8, cout=0, overflow=1.
- a=15, b=1, cin=0 -> sum=0, cout=1, overflow=0.
- a=7, b=8, cin=1 -> sum=0, cout=1, overflow=0. Also a=6, b=~2 (13), cin=1 -> sum=4, cout=1 (subtract 6-2).
- Start pulsed again, and a/b changed, during RUN of a=2, b=2 -> result sum=4; the second start is ignored; exactly one done pulse.
- Back-to-back: start held high through DONE with a=1, b=1, then a=9, b=9 -> done pulses 5 cycles apart. Results: sum=2, then sum=2 with cout=1, overflow=1.
- Assert reset 2 cycles into RUN -> busy, done, sum, cout, overflow go to 0 immediately with no done pulse. A new start after release then completes normally.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop add a + b + cin
// LSB first over WIDTH clocks; results are registered and held until the next completion.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             carry_next;

    assign bit_s      = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    psum_d  = '0;
                    count_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_next;
                psum_d  = {bit_s, psum_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    // carry_q here is the carry into the MSB slice
                    sum_d   = {bit_s, psum_q[WIDTH-1:1]};
                    cout_d  = carry_next;
                    ovf_d   = carry_q ^ carry_next;
                    count_d = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
